// File: rtl/cla_pkg.sv
// Shared defaults and parameter helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

   localparam int unsigned DefN   = 32;
   localparam int unsigned DefSeg = 8;

   function automatic int unsigned cla_stages(input int unsigned n, input int unsigned seg);
      return n / seg;
   endfunction

   // Legal shapes: whole 4-bit CLA groups per segment and whole segments per operand.
   function automatic bit cla_params_ok(input int unsigned n, input int unsigned seg);
      return (seg >= 4) && (seg % 4 == 0) && (n >= seg) && (n % seg == 0);
   endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit carry-lookahead segment built from 4-bit CLA groups.
module cla_seg
   import cla_pkg::*;
#(
   parameter int unsigned SEG = DefSeg
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] s,
   output logic           cout
);

   localparam int unsigned GROUPS = SEG / 4;

   logic [SEG-1:0]    p, g, c;
   logic [GROUPS-1:0] gp, gg;
   logic [GROUPS:0]   gc;

   always_comb begin
      p  = a ^ b;
      g  = a & b;
      c  = '0;
      gp = '0;
      gg = '0;
      gc = '0;
      gc[0] = cin;
      // Group carries from group propagate/generate only; unrolls to a flat lookahead.
      for (int unsigned i = 0; i < GROUPS; i++) begin
         gp[i] = &p[4*i +: 4];
         gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
         gc[i+1] = gg[i] | (gp[i] & gc[i]);
      end
      for (int unsigned i = 0; i < GROUPS; i++) begin
         c[4*i]   = gc[i];
         c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
         c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
         c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                  | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
      end
      s    = p ^ c;
      cout = gc[GROUPS];
   end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: stage k adds segment k using the carry registered by stage k-1;
// operands ride along with the carry and finished segments ride along to the output.
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int unsigned N   = DefN,
   parameter int unsigned SEG = DefSeg
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int unsigned STAGES = cla_stages(N, SEG);

   if (!cla_params_ok(N, SEG)) begin : g_bad_params
      $error("cla_pipe_addsub: N must be a nonzero multiple of SEG and SEG a multiple of 4");
   end

   logic           en;
   logic [N-1:0]   b_x;
   logic [N-1:0]   a_q   [STAGES];
   logic [N-1:0]   b_q   [STAGES];
   logic [N-1:0]   s_q   [STAGES];
   logic           v_q   [STAGES];
   logic           c_q   [STAGES];
   logic           ovf_q;
   logic [N-1:0]   st_a  [STAGES];
   logic [N-1:0]   st_b  [STAGES];
   logic [N-1:0]   st_s  [STAGES];
   logic [N-1:0]   s_d   [STAGES];
   logic           st_v  [STAGES];
   logic           st_ci [STAGES];
   logic [SEG-1:0] seg_s [STAGES];
   logic           seg_co[STAGES];
   logic           msb_ci, ovf_d;

   assign en       = !v_q[STAGES-1] || out_ready;
   assign in_ready = en || !reset;
   assign b_x      = sub ? ~b : b;

   // Stage inputs: the ports for stage 0, the previous stage's registers otherwise.
   always_comb begin
      st_a[0]  = a;
      st_b[0]  = b_x;
      st_s[0]  = '0;
      st_v[0]  = in_valid;
      st_ci[0] = sub;
      for (int unsigned k = 1; k < STAGES; k++) begin
         st_a[k]  = a_q[k-1];
         st_b[k]  = b_q[k-1];
         st_s[k]  = s_q[k-1];
         st_v[k]  = v_q[k-1];
         st_ci[k] = c_q[k-1];
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < STAGES; k++) begin
         s_d[k]                = st_s[k];
         s_d[k][k*SEG +: SEG]  = seg_s[k];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cla_seg #(
         .SEG(SEG)
      ) u_seg (
         .a   (st_a[k][k*SEG +: SEG]),
         .b   (st_b[k][k*SEG +: SEG]),
         .cin (st_ci[k]),
         .s   (seg_s[k]),
         .cout(seg_co[k])
      );

      // Operand bits already consumed are dead past their stage and trim away in synthesis.
      always_ff @(posedge clk) begin
         if (!reset) begin
            v_q[k] <= 1'b0;
            c_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end else if (en) begin
            v_q[k] <= st_v[k];
            c_q[k] <= seg_co[k];
            a_q[k] <= st_a[k];
            b_q[k] <= st_b[k];
            s_q[k] <= s_d[k];
         end
      end
   end

   // Carry into the MSB recovered from the MSB sum bit and its operand bits.
   assign msb_ci = st_a[STAGES-1][N-1] ^ st_b[STAGES-1][N-1] ^ seg_s[STAGES-1][SEG-1];
   assign ovf_d  = msb_ci ^ seg_co[STAGES-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed 8-bit/4-bit table plus handshake corners, and a
// randomised 32-bit/8-bit run against an independent arithmetic model.
module tb_cla_pipe_addsub;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec8_t;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp32_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, ovf8;
   logic [7:0]  a8, b8, sum8;
   logic        in_valid32, in_ready32, sub32, out_valid32, out_ready32, cout32, ovf32;
   logic [31:0] a32, b32, sum32;

   int n_chk  = 0;
   int n_fail = 0;
   int n_out8 = 0;

   vec8_t  tv [14];
   vec8_t  cur8;
   vec8_t  q8 [$];
   exp32_t cur32;
   exp32_t q32 [$];

   cla_pipe_addsub #(
      .N  (8),
      .SEG(4)
   ) u_dut8 (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid8),
      .in_ready (in_ready8),
      .a        (a8),
      .b        (b8),
      .sub      (sub8),
      .out_valid(out_valid8),
      .out_ready(out_ready8),
      .sum      (sum8),
      .cout     (cout8),
      .ovf      (ovf8)
   );

   cla_pipe_addsub #(
      .N  (32),
      .SEG(8)
   ) u_dut32 (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid32),
      .in_ready (in_ready32),
      .a        (a32),
      .b        (b32),
      .sub      (sub32),
      .out_valid(out_valid32),
      .out_ready(out_ready32),
      .sum      (sum32),
      .cout     (cout32),
      .ovf      (ovf32)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   // Unsigned-compare borrow and sign-rule overflow, deliberately unlike the adder itself.
   function automatic exp32_t model32(input logic [31:0] x, input logic [31:0] y,
                                      input logic s);
      exp32_t     r;
      logic [32:0] w;
      if (s) begin
         r.sum  = x - y;
         r.cout = (x >= y);
         r.ovf  = (x[31] != y[31]) && (r.sum[31] != x[31]);
      end else begin
         w      = {1'b0, x} + {1'b0, y};
         r.sum  = w[31:0];
         r.cout = w[32];
         r.ovf  = (x[31] == y[31]) && (r.sum[31] != x[31]);
      end
      return r;
   endfunction

   task automatic drive8(input vec8_t v);
      a8        = v.a;
      b8        = v.b;
      sub8      = v.sub;
      cur8      = v;
      in_valid8 = 1'b1;
   endtask

   // Called just after a falling edge; scores this cycle's transfers, then waits a cycle.
   task automatic tick8();
      vec8_t e;
      #1;
      if (out_valid8 && out_ready8) begin
         n_out8++;
         if (q8.size() == 0) begin
            check("sb8.extra", 64'd1, 64'd0);
         end else begin
            e = q8.pop_front();
            check("sb8.sum", 64'(sum8), 64'(e.sum));
            check("sb8.cout", 64'(cout8), 64'(e.cout));
            check("sb8.ovf", 64'(ovf8), 64'(e.ovf));
         end
      end
      if (in_valid8 && in_ready8) q8.push_back(cur8);
      @(negedge clk);
   endtask

   task automatic tick32();
      exp32_t e;
      #1;
      if (out_valid32 && out_ready32) begin
         if (q32.size() == 0) begin
            check("sb32.extra", 64'd1, 64'd0);
         end else begin
            e = q32.pop_front();
            check("sb32.sum", 64'(sum32), 64'(e.sum));
            check("sb32.cout", 64'(cout32), 64'(e.cout));
            check("sb32.ovf", 64'(ovf32), 64'(e.ovf));
         end
      end
      if (in_valid32 && in_ready32) q32.push_back(cur32);
      @(negedge clk);
   endtask

   // One isolated beat on an idle 8-bit pipe: result must surface exactly 2 cycles later.
   task automatic single8(input vec8_t v, input string tag);
      drive8(v);
      out_ready8 = 1'b1;
      #1 check({tag, ".in_ready"}, 64'(in_ready8), 64'd1);
      @(negedge clk);
      in_valid8 = 1'b0;
      #1 check({tag, ".early"}, 64'(out_valid8), 64'd0);
      @(negedge clk);
      #1;
      check({tag, ".valid"}, 64'(out_valid8), 64'd1);
      check({tag, ".sum"}, 64'(sum8), 64'(v.sum));
      check({tag, ".cout"}, 64'(cout8), 64'(v.cout));
      check({tag, ".ovf"}, 64'(ovf8), 64'(v.ovf));
      @(negedge clk);
   endtask

   // One isolated beat on an idle 32-bit pipe: valid low for 3 cycles, high on the 4th.
   task automatic lat32(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] es, input logic ec, input logic eo, input string tag);
      a32 = x; b32 = y; sub32 = s; in_valid32 = 1'b1; out_ready32 = 1'b1;
      @(negedge clk);
      in_valid32 = 1'b0;
      for (int c = 1; c < 4; c++) begin
         #1 check({tag, ".early"}, 64'(out_valid32), 64'd0);
         @(negedge clk);
      end
      #1;
      check({tag, ".valid"}, 64'(out_valid32), 64'd1);
      check({tag, ".sum"}, 64'(sum32), 64'(es));
      check({tag, ".cout"}, 64'(cout32), 64'(ec));
      check({tag, ".ovf"}, 64'(ovf32), 64'(eo));
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      //         a       b       sub   sum     cout  ovf
      tv[0]  = '{8'd25,  8'd35,  1'b0, 8'd60,  1'b0, 1'b0};
      tv[1]  = '{8'd43,  8'd52,  1'b1, 8'd247, 1'b0, 1'b0};
      tv[2]  = '{8'd100, 8'd100, 1'b0, 8'd200, 1'b0, 1'b1};
      tv[3]  = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
      tv[4]  = '{8'd29,  8'd0,   1'b0, 8'd29,  1'b0, 1'b0};
      tv[5]  = '{8'd78,  8'd90,  1'b0, 8'd168, 1'b0, 1'b1};
      tv[6]  = '{8'd0,   8'd0,   1'b1, 8'd0,   1'b1, 1'b0};
      tv[7]  = '{8'd128, 8'd1,   1'b1, 8'd127, 1'b1, 1'b1};
      tv[8]  = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0};
      tv[9]  = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
      tv[10] = '{8'd15,  8'd1,   1'b0, 8'd16,  1'b0, 1'b0};
      tv[11] = '{8'd52,  8'd43,  1'b1, 8'd9,   1'b1, 1'b0};
      tv[12] = '{8'd0,   8'd1,   1'b1, 8'd255, 1'b0, 1'b0};
      tv[13] = '{8'd127, 8'd255, 1'b1, 8'd128, 1'b0, 1'b1};

      reset = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; sub8 = 1'b0;
      in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0; sub32 = 1'b0;
      cur8 = tv[0];
      cur32 = model32(32'd0, 32'd0, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst.out_valid8", 64'(out_valid8), 64'd0);
      check("rst.sum8", 64'(sum8), 64'd0);
      check("rst.cout8", 64'(cout8), 64'd0);
      check("rst.ovf8", 64'(ovf8), 64'd0);
      check("rst.in_ready8", 64'(in_ready8), 64'd1);
      check("rst.out_valid32", 64'(out_valid32), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1 check("rel.in_ready8", 64'(in_ready8), 64'd1);
      @(negedge clk);

      // Table: each vector alone, with exact latency
      for (int i = 0; i < 14; i++) single8(tv[i], $sformatf("vec%0d", i));

      // Back-to-back stream: results on consecutive cycles, in order
      out_ready8 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c < 14) drive8(tv[c]);
         else in_valid8 = 1'b0;
         if (c >= 2 && c < 16) begin
            #1 check("b2b.valid", 64'(out_valid8), 64'd1);
         end
         tick8();
      end
      check("b2b.drained", 64'(q8.size()), 64'd0);

      // Stall with a full pipe: 3 cycles of out_ready=0
      n_out8 = 0;
      drive8(tv[0]); out_ready8 = 1'b1; tick8();
      drive8(tv[1]); tick8();
      drive8(tv[2]); out_ready8 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("stall.in_ready", 64'(in_ready8), 64'd0);
         check("stall.valid", 64'(out_valid8), 64'd1);
         check("stall.sum", 64'(sum8), 64'(tv[0].sum));
         check("stall.cout", 64'(cout8), 64'(tv[0].cout));
         tick8();
      end
      out_ready8 = 1'b1;
      tick8();
      in_valid8 = 1'b0;
      for (int c = 0; c < 10 && q8.size() != 0; c++) tick8();
      check("stall.drained", 64'(q8.size()), 64'd0);
      check("stall.count", 64'(n_out8), 64'd3);

      // Reset one cycle after two beats are accepted: both must vanish
      drive8(tv[3]); out_ready8 = 1'b0;
      @(negedge clk);
      drive8(tv[5]);
      @(negedge clk);
      in_valid8 = 1'b0; reset = 1'b0;
      @(negedge clk);
      reset = 1'b1; out_ready8 = 1'b1;
      #1 check("midrst.in_ready", 64'(in_ready8), 64'd1);
      for (int c = 0; c < 5; c++) begin
         #1 check("midrst.valid", 64'(out_valid8), 64'd0);
         @(negedge clk);
      end
      single8(tv[4], "midrst.new");

      // 32-bit: latency 4 when unstalled, then random traffic against the model
      lat32(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, "lat32a");
      lat32(32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "lat32b");
      lat32(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "lat32c");
      for (int c = 0; c < 400; c++) begin
         a32         = $urandom;
         b32         = $urandom;
         sub32       = 1'($urandom_range(0, 1));
         in_valid32  = ($urandom_range(0, 3) != 0);
         out_ready32 = ($urandom_range(0, 3) != 0);
         cur32       = model32(a32, b32, sub32);
         tick32();
      end
      in_valid32 = 1'b0; out_ready32 = 1'b1;
      for (int c = 0; c < 20 && q32.size() != 0; c++) tick32();
      check("rand32.drained", 64'(q32.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cla_pipe_addsub.md
CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 Parameter N, default 32, operand width in bits; SHALL be a multiple of SEG and at least SEG.
REQ-002 Parameter SEG, default 8, segment width per pipeline stage; SHALL be a multiple of 4.
REQ-003 Derived constant STAGES = N/SEG, equal to the pipeline depth.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 a  input  N  operand A, unsigned or two's complement.
REQ-009 b  input  N  operand B.
REQ-010 sub  input  1  0 computes A+B; 1 computes A-B.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 sum  output  N  result modulo 2^N.
REQ-014 cout  output  1  carry out of the MSB; for sub=1, 1 means no borrow.
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-017 Pipeline enable en = !out_valid || out_ready; in_ready SHALL equal en, combinationally, with no dependency on in_valid.
REQ-018 When en=0 all stage registers SHALL hold; no beat is lost or duplicated.
REQ-019 Subtract SHALL be A + ~B with carry-in 1; add SHALL use carry-in 0.
REQ-020 Stage k (0..STAGES-1) SHALL compute segment k bits [k*SEG+SEG-1 : k*SEG] from the carry registered by stage k-1, using 4-bit CLA groups with group lookahead inside the segment.
REQ-021 Upper operand segments SHALL be skewed through delay registers so that each segment meets its incoming carry; lower result segments SHALL be deskewed so the full sum emerges aligned.
REQ-022 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid=1, with no stalls in between; throughput SHALL be one beat per cycle.
REQ-023 out_valid, sum, cout and ovf SHALL be registered outputs, stable while out_valid && !out_ready.
REQ-024 ovf SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-025 When a bubble enters (in_valid=0 while en=1), a valid-0 token SHALL propagate; data registers may update freely under a valid-0 token.
REQ-026 When STAGES=1 the block SHALL degenerate to a single registered CLA with identical handshake.

Reset
REQ-027 While reset=0 at a rising edge, all per-stage valid flags and out_valid SHALL clear and sum, cout and ovf SHALL be 0.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight beats; no result for them SHALL ever appear.
REQ-029 in_ready SHALL be 1 during reset and on the first cycle after release.

Structure
REQ-030 Package cla_pkg SHALL hold the default N and SEG, a function computing STAGES, and an elaboration-time check that N%SEG==0 and SEG%4==0.
REQ-031 Sub-module cla_seg (combinational, SEG-bit, inputs a, b, cin; outputs s and cout) SHALL be instantiated once per stage.
REQ-032 No other sub-modules; skew and deskew registers SHALL be generate loops in cla_pipe_addsub.

Verification (N=8, SEG=4, STAGES=2 unless noted)
REQ-033 a=25, b=35, sub=0, out_ready=1 -> exactly 2 cycles later sum=60, cout=0, ovf=0.
REQ-034 a=200, b=100, sub=0 -> sum=44, cout=1; a=100, b=100 -> sum=200, ovf=1; a=43, b=52, sub=1 -> sum=247, cout=0, ovf=0.
REQ-035 Back-to-back beats (25+35, 43+52, 29+0, 78+90) with out_ready=1 -> results 60, 95, 29, 168 on consecutive cycles, in order.
REQ-036 out_ready held 0 for 3 cycles with a full pipeline -> in_ready=0 and outputs stable throughout; on release all results arrive in order, none lost or duplicated.
REQ-037 reset pulsed low one cycle after 2 beats are accepted -> out_valid stays 0 until a new beat is accepted.
REQ-038 N=32, SEG=8 random A, B and sub with random out_ready -> matches a reference model for sum, cout and ovf; latency is 4 cycles when unstalled.
